turn_controller: RTL and testbench
==================================

# turn_controller

Match-level turn sequencer for the two-player artillery game. It grants turns alternately to P1 and P2 and detects the fire key on a rising edge. While the projectile is in flight it reports flight status, then waits a settle period, checks both players for death, and either hands the turn over or ends the match. It produces the `is_in_turn` and `is_run` signals consumed by the per-player control blocks: weapon-mode, aim and movement.

## Interface
- `TURN_FRAMES`, 600: turn length in frames (10 s at 60 Hz); must be ≥2.
- `SETTLE_FRAMES`, 30: post-impact settle length in frames; must be ≥1.
- `frame_clk`  in  1  frame-rate clock, the only clock.
- `Reset`  in  1  synchronous, active-low reset.
- `keycode`  in  8  current USB HID keycode, 0 when no key is held.
- `projectile_done`  in  1  level from the projectile engine: projectile has landed or left the screen.
- `p1_dead`, `p2_dead`  in  1 each  player health reached zero.
- `p1_in_turn`, `p2_in_turn`  out  1 each  turn grant; never both high.
- `is_run`  out  1  projectile in flight.
- `fire`  out  1  one-cycle launch pulse.
- `turn_timer`  out  16  frames remaining in the current turn.
- `game_over`  out  1  match finished.
- `winner`  out  2  01 = P1, 10 = P2, 11 = draw, 00 = none.

## Operation
- States: `P1_TURN`, `P1_FLIGHT`, `P2_TURN`, `P2_FLIGHT`, `SETTLE` (with an `owner` bit), `GAME_OVER`.
- Key edge detection:
  - A key event occurs when `keycode` equals K this cycle and the registered previous keycode does not equal K.
  - Holding a key produces exactly one event.
- `Px_TURN` transitions:
  - Space (8'd44) event → `Px_FLIGHT`, `fire`=1.
  - Otherwise, `turn_timer`==0 → `SETTLE` with `owner`=x (turn forfeited, no fire).
  - Otherwise, `turn_timer` decrements by 1.
  - Fire and expiry in the same cycle: fire wins.
- `Px_FLIGHT`:
  - `is_run`=1.
  - `projectile_done`=1 → `SETTLE` with `owner`=x.
  - `projectile_done` is ignored in every other state.
  - Space events during flight are ignored.
- `SETTLE`:
  - Settle counter is loaded with SETTLE_FRAMES−1 on entry and decrements each cycle.
  - At 0, both dead → `GAME_OVER`, `winner`=11.
  - At 0, only p1 dead → `GAME_OVER`, `winner`=10.
  - At 0, only p2 dead → `GAME_OVER`, `winner`=01.
  - At 0, neither dead → the other player's `TURN`.
- Every `TURN` entry loads `turn_timer` with TURN_FRAMES−1.
- `GAME_OVER`:
  - `game_over`=1, both turn grants low, `winner` held.
  - Enter (8'd40) event → `P1_TURN`, `winner`=00, `game_over`=0.
- Turn grants: `p1_in_turn`=1 in `P1_TURN` and `P1_FLIGHT`; `p2_in_turn` likewise for P2. Both are 0 in `SETTLE` and `GAME_OVER`.

## Timing
- Registered state; all outputs are decoded from registers, with no combinational path from inputs to outputs.
- Reset (Reset=0 at a rising edge) takes priority over everything, including mid-flight and `GAME_OVER`. Reset values:
  - state `P1_TURN`, `p1_in_turn`=1, `p2_in_turn`=0
  - `fire`=0, `is_run`=0, `game_over`=0, `winner`=00
  - `turn_timer`=TURN_FRAMES−1, previous keycode=0
- Fire latency: a Space event sampled at edge N makes `fire`=1 and `is_run`=1 for the cycle after edge N. `fire` drops at edge N+1.
- Settle duration: exactly SETTLE_FRAMES cycles in `SETTLE`.
- Turn duration without fire: exactly TURN_FRAMES cycles in `TURN`.
- Counters never wrap. `turn_timer` holds its value outside `TURN`.

## Configuration
- `TURN_TIMEOUT_EN` defined: turn expiry is enforced as described above.
- `TURN_TIMEOUT_EN` undefined:
  - No expiry; a turn ends only on fire.
  - `turn_timer` is tied to 0 and the turn counter is not synthesized.

## Structure
- Shared package `game_pkg`:
  - state enum `turn_state_t`
  - constants `KEY_SPACE`=8'd44, `KEY_ENTER`=8'd40, `KEY_C`=8'd6
  - winner encodings `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`
- Sub-module `key_edge_detect`: takes the clock, reset, `keycode` and a key constant, and outputs a registered-compare one-cycle event. Two instances: Space and Enter.

## Test plan
- Reset, then Space held for 5 frames at cycle 3 → `fire` high for exactly 1 cycle, `is_run`=1 and `p1_in_turn`=1 until `projectile_done`.
- `projectile_done` 10 cycles after fire, no deaths, SETTLE_FRAMES=4 → `SETTLE` lasts 4 cycles, then `p2_in_turn`=1 and `turn_timer`=TURN_FRAMES−1.
- TURN_FRAMES=8, no keys → P1 forfeits after 8 cycles with `fire` never asserted, then settle, then P2's turn.
- Space event on the cycle `turn_timer`==0 → `fire`=1 and the turn is not forfeited.
- `p1_dead`=`p2_dead`=1 at settle end → `game_over`=1, `winner`=11; Enter event → `P1_TURN`, `winner`=00.
- Reset=0 asserted mid-flight in P2's turn → next cycle matches the reset values (`p1_in_turn`=1, `is_run`=0).

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the artillery game blocks: turn-sequencer
// states, HID keycodes and match-result encodings.
package game_pkg;

  typedef enum logic [2:0] {
    P1_TURN,
    P1_FLIGHT,
    P2_TURN,
    P2_FLIGHT,
    SETTLE,
    GAME_OVER
  } turn_state_t;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_C     = 8'd6;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // The survivor wins; losing both players at once is a draw.
  function automatic logic [1:0] match_result(input logic p1_dead, input logic p2_dead);
    logic [1:0] result;
    result = WIN_NONE;
    if (p1_dead && p2_dead) result = WIN_DRAW;
    else if (p1_dead)       result = WIN_P2;
    else if (p2_dead)       result = WIN_P1;
    return result;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// One-cycle event when the held keycode becomes a given key; holding the key
// yields a single event because the previous keycode is kept in a register.
module key_edge_detect (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] key,
  output logic       key_event
);

  logic [7:0] prev_keycode;

  always_ff @(posedge frame_clk) begin
    if (!Reset) prev_keycode <= 8'd0;
    else        prev_keycode <= keycode;
  end

  assign key_event = (keycode == key) && (prev_keycode != key);

endmodule

// File: rtl/turn_controller.sv
// Match-level turn sequencer: alternates P1/P2 turns, launches on Space,
// settles after impact and ends the match on a death. Define TURN_TIMEOUT_EN
// to enforce the per-turn frame limit; otherwise a turn ends only on fire.
module turn_controller
  import game_pkg::*;
#(
  parameter int TURN_FRAMES   = 600,
  parameter int SETTLE_FRAMES = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        projectile_done,
  input  logic        p1_dead,
  input  logic        p2_dead,
  output logic        p1_in_turn,
  output logic        p2_in_turn,
  output logic        is_run,
  output logic        fire,
  output logic [15:0] turn_timer,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_FRAMES - 1);

  turn_state_t state, state_next;
  logic        owner, owner_next;
  logic [15:0] settle_cnt, settle_next;
  logic [1:0]  winner_next;
  logic        fire_next;
  logic        space_event, enter_event;
  logic        timeout;

  key_edge_detect space_detect (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key       (KEY_SPACE),
    .key_event (space_event)
  );

  key_edge_detect enter_detect (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key       (KEY_ENTER),
    .key_event (enter_event)
  );

`ifdef TURN_TIMEOUT_EN
  localparam logic [15:0] TURN_LOAD = 16'(TURN_FRAMES - 1);

  logic [15:0] timer_q, timer_next;

  always_ff @(posedge frame_clk) begin
    if (!Reset) timer_q <= TURN_LOAD;
    else        timer_q <= timer_next;
  end

  assign turn_timer = timer_q;
  assign timeout    = (timer_q == 16'd0);
`else
  assign turn_timer = 16'd0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    settle_next = settle_cnt;
    winner_next = winner;
    fire_next   = 1'b0;
`ifdef TURN_TIMEOUT_EN
    timer_next  = timer_q;
`endif
    case (state)
      P1_TURN, P2_TURN: begin
        // A launch in the last frame of the turn still counts.
        if (space_event) begin
          state_next = (state == P1_TURN) ? P1_FLIGHT : P2_FLIGHT;
          fire_next  = 1'b1;
        end else if (timeout) begin
          state_next  = SETTLE;
          owner_next  = (state == P2_TURN);
          settle_next = SETTLE_LOAD;
        end else begin
`ifdef TURN_TIMEOUT_EN
          timer_next = timer_q - 16'd1;
`endif
        end
      end
      P1_FLIGHT, P2_FLIGHT: begin
        if (projectile_done) begin
          state_next  = SETTLE;
          owner_next  = (state == P2_FLIGHT);
          settle_next = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 16'd0) begin
          if (p1_dead || p2_dead) begin
            state_next  = GAME_OVER;
            winner_next = match_result(p1_dead, p2_dead);
          end else begin
            state_next = owner ? P1_TURN : P2_TURN;
`ifdef TURN_TIMEOUT_EN
            timer_next = TURN_LOAD;
`endif
          end
        end else begin
          settle_next = settle_cnt - 16'd1;
        end
      end
      GAME_OVER: begin
        if (enter_event) begin
          state_next  = P1_TURN;
          winner_next = WIN_NONE;
`ifdef TURN_TIMEOUT_EN
          timer_next  = TURN_LOAD;
`endif
        end
      end
      default: begin
        state_next = P1_TURN;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state      <= P1_TURN;
      owner      <= 1'b0;
      settle_cnt <= SETTLE_LOAD;
      winner     <= WIN_NONE;
      fire       <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      settle_cnt <= settle_next;
      winner     <= winner_next;
      fire       <= fire_next;
    end
  end

  assign p1_in_turn = (state == P1_TURN) || (state == P1_FLIGHT);
  assign p2_in_turn = (state == P2_TURN) || (state == P2_FLIGHT);
  assign is_run     = (state == P1_FLIGHT) || (state == P2_FLIGHT);
  assign game_over  = (state == GAME_OVER);

  assert property (@(posedge frame_clk) !(p1_in_turn && p2_in_turn));
  assert property (@(posedge frame_clk) 32'(turn_timer) < TURN_FRAMES);

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: a vector table, hand-written
// corner sequences and random stimulus against a frame-level game model.
module tb_turn_controller;

  localparam int TF = 8;
  localparam int SF = 4;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_TURN   = 0;
  localparam int PH_FLIGHT = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_OVER   = 3;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic        projectile_done;
  logic        p1_dead, p2_dead;
  logic        p1_in_turn, p2_in_turn;
  logic        is_run, fire, game_over;
  logic [15:0] turn_timer;
  logic [1:0]  winner;

  int total = 0;
  int bad   = 0;

  turn_controller #(.TURN_FRAMES(TF), .SETTLE_FRAMES(SF)) dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .keycode         (keycode),
    .projectile_done (projectile_done),
    .p1_dead         (p1_dead),
    .p2_dead         (p2_dead),
    .p1_in_turn      (p1_in_turn),
    .p2_in_turn      (p2_in_turn),
    .is_run          (is_run),
    .fire            (fire),
    .turn_timer      (turn_timer),
    .game_over       (game_over),
    .winner          (winner)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Game model: whose turn it is, what phase the match is in, and how many
  // frames are left in the turn or the settle period.
  int         m_phase, m_player, m_left, m_settle;
  logic [1:0] m_win;
  logic       m_fire;
  logic [7:0] m_prev;

  task automatic model_reset();
    m_phase  = PH_TURN;
    m_player = 1;
    m_left   = TF - 1;
    m_settle = 0;
    m_win    = 2'b00;
    m_fire   = 1'b0;
    m_prev   = 8'd0;
  endtask

  task automatic model_step(input logic rst_n, input logic [7:0] key, input logic done,
                            input logic d1, input logic d2);
    bit space, enter;
    space = (key == 8'd44) && (m_prev != 8'd44);
    enter = (key == 8'd40) && (m_prev != 8'd40);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_fire = 1'b0;
      case (m_phase)
        PH_TURN: begin
          if (space) begin
            m_phase = PH_FLIGHT;
            m_fire  = 1'b1;
          end else if (TO_EN && m_left == 0) begin
            m_phase  = PH_SETTLE;
            m_settle = SF;
          end else if (TO_EN) begin
            m_left = m_left - 1;
          end
        end
        PH_FLIGHT: begin
          if (done) begin
            m_phase  = PH_SETTLE;
            m_settle = SF;
          end
        end
        PH_SETTLE: begin
          m_settle = m_settle - 1;
          if (m_settle == 0) begin
            if (d1 && d2)  begin m_phase = PH_OVER; m_win = 2'b11; end
            else if (d1)   begin m_phase = PH_OVER; m_win = 2'b10; end
            else if (d2)   begin m_phase = PH_OVER; m_win = 2'b01; end
            else begin
              m_player = 3 - m_player;
              m_phase  = PH_TURN;
              m_left   = TF - 1;
            end
          end
        end
        default: begin
          if (enter) begin
            m_phase  = PH_TURN;
            m_player = 1;
            m_win    = 2'b00;
            m_left   = TF - 1;
          end
        end
      endcase
      m_prev = key;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit active;
    active = (m_phase == PH_TURN) || (m_phase == PH_FLIGHT);
    check_output("model p1_in_turn", 32'(p1_in_turn), 32'(active && m_player == 1));
    check_output("model p2_in_turn", 32'(p2_in_turn), 32'(active && m_player == 2));
    check_output("model is_run", 32'(is_run), 32'(m_phase == PH_FLIGHT));
    check_output("model fire", 32'(fire), 32'(m_fire));
    check_output("model game_over", 32'(game_over), 32'(m_phase == PH_OVER));
    check_output("model winner", 32'(winner), 32'(m_win));
    check_output("model turn_timer", 32'(turn_timer), TO_EN ? 32'(m_left) : 32'd0);
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic [7:0] key, input logic done,
                                input logic d1, input logic d2);
    Reset           = rst_n;
    keycode         = key;
    projectile_done = done;
    p1_dead         = d1;
    p2_dead         = d2;
    @(posedge frame_clk);
    model_step(rst_n, key, done, d1, d2);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] key;
    logic       done, d1, d2;
    logic       e_p1, e_p2, e_run, e_fire, e_over;
    logic [1:0] e_win;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic [7:0] key, input logic done,
                     input logic d1, input logic d2, input logic e_p1, input logic e_p2,
                     input logic e_run, input logic e_fire, input logic e_over,
                     input logic [1:0] e_win);
    vecs.push_back('{rst_n, key, done, d1, d2, e_p1, e_p2, e_run, e_fire, e_over, e_win});
  endtask

  initial begin
    Reset = 1'b0; keycode = 8'd0; projectile_done = 1'b0; p1_dead = 1'b0; p2_dead = 1'b0;
    model_reset();

    //   rst key  dn d1 d2   p1 p2 run fire over win
    add(0, 8'd0,  0, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  1, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   1, 0, 1, 1, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   1, 0, 1, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   1, 0, 1, 0, 0, 2'b00);
    add(1, 8'd0,  1, 0, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 0,   0, 1, 0, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   0, 1, 1, 1, 0, 2'b00);
    add(1, 8'd0,  0, 0, 0,   0, 1, 1, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   0, 1, 1, 0, 0, 2'b00);
    add(1, 8'd0,  1, 1, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 1,   0, 0, 0, 0, 1, 2'b11);
    add(1, 8'd44, 0, 0, 0,   0, 0, 0, 0, 1, 2'b11);
    add(1, 8'd40, 0, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd40, 0, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   1, 0, 1, 1, 0, 2'b00);
    add(1, 8'd0,  1, 0, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 1,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 0, 1,   0, 0, 0, 0, 1, 2'b01);
    add(1, 8'd40, 0, 0, 0,   1, 0, 0, 0, 0, 2'b00);
    add(1, 8'd44, 0, 0, 0,   1, 0, 1, 1, 0, 2'b00);
    add(1, 8'd0,  1, 1, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 0,   0, 0, 0, 0, 0, 2'b00);
    add(1, 8'd0,  0, 1, 0,   0, 0, 0, 0, 1, 2'b10);
    add(1, 8'd40, 0, 0, 0,   1, 0, 0, 0, 0, 2'b00);

    $display("[TB] vector table: %0d rows", vecs.size());
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].key, vecs[i].done, vecs[i].d1, vecs[i].d2);
      check_output($sformatf("row%0d p1_in_turn", i), 32'(p1_in_turn), 32'(vecs[i].e_p1));
      check_output($sformatf("row%0d p2_in_turn", i), 32'(p2_in_turn), 32'(vecs[i].e_p2));
      check_output($sformatf("row%0d is_run", i), 32'(is_run), 32'(vecs[i].e_run));
      check_output($sformatf("row%0d fire", i), 32'(fire), 32'(vecs[i].e_fire));
      check_output($sformatf("row%0d game_over", i), 32'(game_over), 32'(vecs[i].e_over));
      check_output($sformatf("row%0d winner", i), 32'(winner), 32'(vecs[i].e_win));
    end

    // Reset in the middle of P2's flight.
    $display("[TB] sequence: reset during P2 flight");
    apply_stimulus(0, 8'd0, 0, 0, 0);
    apply_stimulus(1, 8'd44, 0, 0, 0);
    apply_stimulus(1, 8'd0, 1, 0, 0);
    for (int i = 0; i < SF; i++) apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqA p2 turn after settle", 32'(p2_in_turn), 32'd1);
    check_output("seqA timer on P2 entry", 32'(turn_timer), TO_EN ? 32'(TF - 1) : 32'd0);
    apply_stimulus(1, 8'd44, 0, 0, 0);
    check_output("seqA p2 flight is_run", 32'(is_run), 32'd1);
    apply_stimulus(0, 8'd0, 0, 0, 0);
    check_output("seqA reset p1_in_turn", 32'(p1_in_turn), 32'd1);
    check_output("seqA reset p2_in_turn", 32'(p2_in_turn), 32'd0);
    check_output("seqA reset is_run", 32'(is_run), 32'd0);
    check_output("seqA reset fire", 32'(fire), 32'd0);
    check_output("seqA reset timer", 32'(turn_timer), TO_EN ? 32'(TF - 1) : 32'd0);

`ifdef TURN_TIMEOUT_EN
    // P1 lets the turn run out: exactly TF frames, no launch.
    $display("[TB] sequence: turn forfeit");
    apply_stimulus(0, 8'd0, 0, 0, 0);
    for (int i = 0; i < TF - 1; i++) apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqB last turn frame p1", 32'(p1_in_turn), 32'd1);
    check_output("seqB last turn frame timer", 32'(turn_timer), 32'd0);
    apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqB forfeit leaves turn", 32'(p1_in_turn), 32'd0);
    check_output("seqB forfeit no fire", 32'(fire), 32'd0);
    for (int i = 0; i < SF - 1; i++) apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqB still settling", 32'(p2_in_turn), 32'd0);
    apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqB p2 turn", 32'(p2_in_turn), 32'd1);
    check_output("seqB p2 timer", 32'(turn_timer), 32'(TF - 1));

    // Space on the last frame of the turn wins over expiry.
    $display("[TB] sequence: fire on final frame");
    apply_stimulus(0, 8'd0, 0, 0, 0);
    for (int i = 0; i < TF - 1; i++) apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqC timer at zero", 32'(turn_timer), 32'd0);
    apply_stimulus(1, 8'd44, 0, 0, 0);
    check_output("seqC fire at expiry", 32'(fire), 32'd1);
    check_output("seqC in flight", 32'(is_run), 32'd1);
    check_output("seqC p1 keeps turn", 32'(p1_in_turn), 32'd1);
    check_output("seqC timer held", 32'(turn_timer), 32'd0);
`else
    // Without the timeout a turn never expires.
    $display("[TB] sequence: no expiry");
    apply_stimulus(0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 3 * TF; i++) apply_stimulus(1, 8'd0, 0, 0, 0);
    check_output("seqB p1 keeps turn", 32'(p1_in_turn), 32'd1);
    check_output("seqB timer tied", 32'(turn_timer), 32'd0);
    apply_stimulus(1, 8'd44, 0, 0, 0);
    check_output("seqB late fire", 32'(fire), 32'd1);
`endif

    $display("[TB] random phase");
    apply_stimulus(0, 8'd0, 0, 0, 0);
    begin
      logic [7:0] key;
      key = 8'd0;
      for (int i = 0; i < 3000; i++) begin
        logic r_rst, r_done, r_d1, r_d2;
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: key = 8'd0;
            4, 5:       key = 8'd44;
            6:          key = 8'd40;
            7:          key = 8'd6;
            default:    key = 8'($urandom_range(0, 255));
          endcase
        end
        r_rst  = ($urandom_range(0, 149) != 0);
        r_done = ($urandom_range(0, 3) == 0);
        r_d1   = ($urandom_range(0, 7) == 0);
        r_d2   = ($urandom_range(0, 7) == 0);
        apply_stimulus(r_rst, key, r_done, r_d1, r_d2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
